vend_fsm_param: RTL and testbench

//  Parametrised vending controller: accumulates coin credit, serves N_PROD products with per-product

---
 rtl/vend_pkg.sv | 13 +
 rtl/vend_price_lut.sv | 23 ++
 rtl/vend_fsm_param.sv | 176 +++++++++++++++++
 tb/tb_vend_fsm_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding and coin width.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    localparam int COIN_W = 4;

endpackage

// File: rtl/vend_price_lut.sv
// Combinational product price lookup with selector range check.
module vend_price_lut #(
    parameter int                   CW     = 8,
    parameter int                   N_PROD = 4,
    parameter int                   SEL_W  = 2,
    parameter logic [N_PROD*CW-1:0] PRICES = {8'd9, 8'd7, 8'd3, 8'd2}
) (
    input  logic [SEL_W-1:0] sel_id_i,
    output logic [CW-1:0]    price_o,
    output logic             in_range_o
);

    always_comb begin
        price_o    = '0;
        in_range_o = (int'(sel_id_i) < N_PROD);
        for (int i = 0; i < N_PROD; i++) begin
            if (int'(sel_id_i) == i) begin
                price_o = PRICES[i*CW +: CW];
            end
        end
    end

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: coin credit accumulation, product selection, dispense and
// change/refund hand-off to the hopper over a valid/ready handshake.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int                   CW       = 8,
    parameter int                   N_PROD   = 4,
    parameter int                   SEL_W    = 2,
    parameter logic [N_PROD*CW-1:0] PRICES   = {8'd9, 8'd7, 8'd3, 8'd2},
    parameter logic [CW-1:0]        MAX_CRED = 8'd200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coin_valid,
    input  logic [COIN_W-1:0] coin_value,
    input  logic              sel_valid,
    input  logic [SEL_W-1:0]  sel_id,
    input  logic              cancel,
    input  logic              change_ready,
    output logic [CW-1:0]     credit,
    output logic              coin_reject,
    output logic              dispense,
    output logic [SEL_W-1:0]  dispense_id,
    output logic              err_funds,
    output logic              err_sel,
    output logic              change_valid,
    output logic [CW-1:0]     change_amt,
    output logic              busy
);

    state_e           state_q, state_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic [CW-1:0]    price_q, price_d;
    logic             coin_reject_q, coin_reject_d;
    logic             dispense_q, dispense_d;
    logic [SEL_W-1:0] dispense_id_q, dispense_id_d;
    logic             err_funds_q, err_funds_d;
    logic             err_sel_q, err_sel_d;
    logic             change_valid_q, change_valid_d;
    logic [CW-1:0]    change_amt_q, change_amt_d;
    logic             busy_q, busy_d;

    logic [CW-1:0]    lut_price;
    logic             lut_in_range;
    logic [CW:0]      coin_sum;
    logic             coin_ok;
    logic [CW-1:0]    remainder;

    vend_price_lut #(
        .CW     (CW),
        .N_PROD (N_PROD),
        .SEL_W  (SEL_W),
        .PRICES (PRICES)
    ) u_lut (
        .sel_id_i   (sel_id),
        .price_o    (lut_price),
        .in_range_o (lut_in_range)
    );

    // One extra bit on the sum so an overflowing coin is rejected rather than wrapping.
    assign coin_sum  = (CW+1)'(credit_q) + (CW+1)'(coin_value);
    assign coin_ok   = (coin_sum <= (CW+1)'(MAX_CRED));
    assign remainder = credit_q - price_q;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        price_d        = price_q;
        coin_reject_d  = 1'b0;
        dispense_d     = 1'b0;
        dispense_id_d  = '0;
        err_funds_d    = 1'b0;
        err_sel_d      = 1'b0;
        change_valid_d = change_valid_q;
        change_amt_d   = change_amt_q;

        case (state_q)
            IDLE, CREDIT: begin
                if (cancel && (state_q == CREDIT)) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    coin_reject_d  = coin_valid;
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (!lut_in_range) begin
                        err_sel_d = 1'b1;
                    end else if (credit_q < lut_price) begin
                        err_funds_d = 1'b1;
                    end else begin
                        state_d       = VEND;
                        price_d       = lut_price;
                        dispense_d    = 1'b1;
                        dispense_id_d = sel_id;
                    end
                end else if (cancel) begin
                    // Cancel with no credit does nothing, but still blocks a coin.
                    coin_reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[CW-1:0];
                        if (coin_sum != '0) begin
                            state_d = CREDIT;
                        end
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_valid;
                credit_d      = remainder;
                if (remainder != '0) begin
                    state_d        = CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = remainder;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_ready) begin
                    state_d        = IDLE;
                    credit_d       = '0;
                    change_valid_d = 1'b0;
                    change_amt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            price_q        <= '0;
            coin_reject_q  <= 1'b0;
            dispense_q     <= 1'b0;
            dispense_id_q  <= '0;
            err_funds_q    <= 1'b0;
            err_sel_q      <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            price_q        <= price_d;
            coin_reject_q  <= coin_reject_d;
            dispense_q     <= dispense_d;
            dispense_id_q  <= dispense_id_d;
            err_funds_q    <= err_funds_d;
            err_sel_q      <= err_sel_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            busy_q         <= busy_d;
        end
    end

    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign dispense     = dispense_q;
    assign dispense_id  = dispense_id_q;
    assign err_funds    = err_funds_q;
    assign err_sel      = err_sel_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench for vend_fsm_param: a 4-product build plus a 3-product build for range errors.
module tb_vend_fsm_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = '0;
    logic       cancel = 1'b0;
    logic       change_ready = 1'b0;
    logic [7:0] credit;
    logic       coin_reject, dispense, err_funds, err_sel, change_valid, busy;
    logic [1:0] dispense_id;
    logic [7:0] change_amt;

    logic       b_coin_valid = 1'b0;
    logic [3:0] b_coin_value = '0;
    logic       b_sel_valid = 1'b0;
    logic [1:0] b_sel_id = '0;
    logic       b_cancel = 1'b0;
    logic       b_change_ready = 1'b0;
    logic [7:0] b_credit;
    logic       b_coin_reject, b_dispense, b_err_funds, b_err_sel, b_change_valid, b_busy;
    logic [1:0] b_dispense_id;
    logic [7:0] b_change_amt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vend_fsm_param dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel), .change_ready(change_ready),
        .credit(credit), .coin_reject(coin_reject),
        .dispense(dispense), .dispense_id(dispense_id),
        .err_funds(err_funds), .err_sel(err_sel),
        .change_valid(change_valid), .change_amt(change_amt),
        .busy(busy)
    );

    vend_fsm_param #(
        .N_PROD(3),
        .PRICES({8'd7, 8'd3, 8'd2})
    ) dut3 (
        .clk(clk), .rst(rst),
        .coin_valid(b_coin_valid), .coin_value(b_coin_value),
        .sel_valid(b_sel_valid), .sel_id(b_sel_id),
        .cancel(b_cancel), .change_ready(b_change_ready),
        .credit(b_credit), .coin_reject(b_coin_reject),
        .dispense(b_dispense), .dispense_id(b_dispense_id),
        .err_funds(b_err_funds), .err_sel(b_err_sel),
        .change_valid(b_change_valid), .change_amt(b_change_amt),
        .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs settle 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        coin_valid   = 1'b0;
        coin_value   = '0;
        sel_valid    = 1'b0;
        sel_id       = '0;
        cancel       = 1'b0;
        change_ready = 1'b0;
        b_sel_valid  = 1'b0;
        b_sel_id     = '0;
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        idle_inputs();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_credit", 32'(credit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_change_valid", 32'(change_valid), 0);
        chk("rst_dispense", 32'(dispense), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: coins 5 + 2, buy product 1 (price 3), change 4
        coin(4'd5);
        chk("t1_credit5", 32'(credit), 5);
        coin(4'd2);
        chk("t1_credit7", 32'(credit), 7);
        sel_valid = 1'b1; sel_id = 2'd1;
        tick(); idle_inputs();
        chk("t1_dispense", 32'(dispense), 1);
        chk("t1_dispense_id", 32'(dispense_id), 1);
        chk("t1_busy_vend", 32'(busy), 1);
        tick();
        chk("t1_dispense_pulse", 32'(dispense), 0);
        chk("t1_change_valid", 32'(change_valid), 1);
        chk("t1_change_amt", 32'(change_amt), 4);
        chk("t1_credit_rem", 32'(credit), 4);
        change_ready = 1'b1;
        tick(); idle_inputs();
        chk("t1_hs_valid", 32'(change_valid), 0);
        chk("t1_hs_credit", 32'(credit), 0);
        chk("t1_hs_busy", 32'(busy), 0);

        // 2: exact payment, no change
        coin(4'd2);
        chk("t2_credit", 32'(credit), 2);
        sel_valid = 1'b1; sel_id = 2'd0;
        tick(); idle_inputs();
        chk("t2_dispense", 32'(dispense), 1);
        chk("t2_dispense_id", 32'(dispense_id), 0);
        tick();
        chk("t2_no_change", 32'(change_valid), 0);
        chk("t2_credit0", 32'(credit), 0);
        chk("t2_busy", 32'(busy), 0);

        // 3: insufficient funds; out-of-range select on 3-product build
        coin(4'd2);
        sel_valid = 1'b1; sel_id = 2'd3;
        b_sel_valid = 1'b1; b_sel_id = 2'd3;
        tick(); idle_inputs();
        chk("t3_err_funds", 32'(err_funds), 1);
        chk("t3_no_err_sel", 32'(err_sel), 0);
        chk("t3_no_dispense", 32'(dispense), 0);
        chk("t3_credit", 32'(credit), 2);
        chk("t3_b_err_sel", 32'(b_err_sel), 1);
        chk("t3_b_no_err_funds", 32'(b_err_funds), 0);
        chk("t3_b_busy", 32'(b_busy), 0);
        tick();
        chk("t3_err_funds_pulse", 32'(err_funds), 0);
        chk("t3_b_err_sel_pulse", 32'(b_err_sel), 0);
        cancel = 1'b1;
        tick(); idle_inputs();
        chk("t3_refund_amt", 32'(change_amt), 2);
        change_ready = 1'b1;
        tick(); idle_inputs();
        chk("t3_refund_done", 32'(credit), 0);

        // 4: credit ceiling
        for (int i = 0; i < 13; i++) coin(4'd15);
        coin(4'd3);
        chk("t4_credit198", 32'(credit), 198);
        coin(4'd5);
        chk("t4_reject", 32'(coin_reject), 1);
        chk("t4_credit_kept", 32'(credit), 198);
        coin(4'd2);
        chk("t4_no_reject", 32'(coin_reject), 0);
        chk("t4_credit200", 32'(credit), 200);
        cancel = 1'b1;
        tick(); idle_inputs();
        chk("t4_refund_amt", 32'(change_amt), 200);
        change_ready = 1'b1;
        tick(); idle_inputs();

        // 5: cancel + select + coin together, hopper stalls
        coin(4'd7);
        chk("t5_credit", 32'(credit), 7);
        cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0;
        coin_valid = 1'b1; coin_value = 4'd3;
        tick(); idle_inputs();
        chk("t5_change_valid", 32'(change_valid), 1);
        chk("t5_change_amt", 32'(change_amt), 7);
        chk("t5_coin_reject", 32'(coin_reject), 1);
        chk("t5_no_dispense", 32'(dispense), 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                coin_valid = 1'b1; coin_value = 4'd1;
            end
            tick(); idle_inputs();
            chk("t5_hold_amt", 32'(change_amt), 7);
            chk("t5_hold_valid", 32'(change_valid), 1);
            chk("t5_hold_busy", 32'(busy), 1);
            if (i == 1) chk("t5_busy_coin_reject", 32'(coin_reject), 1);
        end
        chk("t5_credit_held", 32'(credit), 7);
        change_ready = 1'b1;
        tick(); idle_inputs();
        chk("t5_done", 32'(change_valid), 0);

        // 6: asynchronous reset while change is pending
        coin(4'd4);
        cancel = 1'b1;
        tick(); idle_inputs();
        chk("t6_pending", 32'(change_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(change_valid), 0);
        chk("t6_rst_amt", 32'(change_amt), 0);
        chk("t6_rst_credit", 32'(credit), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        coin(4'd3);
        chk("t6_new_coin", 32'(credit), 3);
        chk("t6_no_change", 32'(change_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
